// File: rtl/mem_burst_master.sv
// mem_burst_master: burst initiator for a single-port synchronous memory.
// A client command (read or write, start address, length minus one) is taken over a
// valid/ready handshake. The block then steps through consecutive memory addresses.
// Write beats come in on a wr_valid/wr_ready stream. Read beats go out on a
// rd_valid/rd_ready stream.
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; cmd_rw (1=write), cmd_addr, cmd_len
//   wr_data/wr_valid/wr_ready  write beat stream
//   rd_data/rd_valid/rd_ready  read beat stream (rd_data registered)
//   busy                       high whenever the FSM is not idle
//   done                       one-cycle pulse after the last beat of a burst
//   mem_valid/mem_rw/mem_addr/mem_din  memory request; mem_dout  memory read data
//                                      (registered by memory)
module mem_burst_master #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_rw,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          busy,
  output logic          done,
  output logic          mem_valid,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StReadWait,
    StReadHold,
    StDone
  } state_e;

  state_e        state_q;
  logic [AW-1:0] cur_addr_q;
  logic [LW-1:0] remaining_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic          done_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            cur_addr_q  <= cmd_addr;
            remaining_q <= cmd_len;
            state_q     <= cmd_rw ? StWrite : StRead;
          end
        end
        StWrite: begin
          // The memory captures the beat on this same edge.
          if (wr_valid) begin
            if (remaining_q == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              // Address wraps modulo 2**AW inside a burst.
              cur_addr_q  <= cur_addr_q + AW'(1);
              remaining_q <= remaining_q - LW'(1);
            end
          end
        end
        StRead: begin
          state_q <= StReadWait;
        end
        StReadWait: begin
          // mem_dout carries the word addressed on the previous edge.
          rd_data_q  <= mem_dout;
          rd_valid_q <= 1'b1;
          state_q    <= StReadHold;
        end
        StReadHold: begin
          if (rd_ready) begin
            rd_valid_q <= 1'b0;
            if (remaining_q == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              cur_addr_q  <= cur_addr_q + AW'(1);
              remaining_q <= remaining_q - LW'(1);
              state_q     <= StRead;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Memory request is combinational from state so that a write beat reaches the
  // memory in the cycle it is offered, and reset removes it immediately.
  assign cmd_ready = (state_q == StIdle);
  assign wr_ready  = (state_q == StWrite);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign mem_valid = ((state_q == StWrite) && wr_valid) || (state_q == StRead);
  assign mem_rw    = (state_q == StWrite);
  assign mem_addr  = cur_addr_q;
  assign mem_din   = (state_q == StWrite) ? wr_data : '0;

endmodule
